// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state codes,
// handshake level names and bus widths used by the EX-stage divider.
package div_unit_pkg;

    // Width of one general-purpose register and of the HI/LO pair
    localparam int unsigned RegBusW       = 32;
    localparam int unsigned DoubleRegBusW = 2 * RegBusW;

    // Divider FSM state codes
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Result-ready levels
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Request levels on start_i
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}; ready_o flags a valid result.
// Optional build macro DIV_EARLY_OUT_EN: when defined, an operation whose
// |dividend| < |divisor| completes at acceptance with {dividend, 0}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = RegBusW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned       CntW    = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(DATA_W);
    localparam logic [CntW-1:0]   CntOne  = CntW'(1);

    // State and working registers
    div_state_e            r_state;
    logic [CntW-1:0]       r_cnt;
    logic                  r_signed;
    logic                  r_neg1;      // dividend was negative (signed op)
    logic                  r_neg2;      // divisor was negative (signed op)
    logic [DATA_W-1:0]     r_divisor;   // |divisor|
    logic [DATA_W-1:0]     r_rem;       // partial remainder
    logic [DATA_W-1:0]     r_quot;      // remaining dividend bits / quotient bits
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    // Next-state values
    div_state_e            w_state_n;
    logic [CntW-1:0]       w_cnt_n;
    logic                  w_signed_n;
    logic                  w_neg1_n;
    logic                  w_neg2_n;
    logic [DATA_W-1:0]     w_divisor_n;
    logic [DATA_W-1:0]     w_rem_n;
    logic [DATA_W-1:0]     w_quot_n;
    logic [2*DATA_W-1:0]   w_result_n;
    logic                  w_ready_n;

    // Datapath wires
    logic                  w_op1_neg;
    logic                  w_op2_neg;
    logic [DATA_W-1:0]     w_abs1;
    logic [DATA_W-1:0]     w_abs2;
    logic [DATA_W:0]       w_partial;
    logic                  w_borrow;
    logic [DATA_W-1:0]     w_rem_sub;
    logic [DATA_W-1:0]     w_quot_fix;
    logic [DATA_W-1:0]     w_rem_fix;
`ifdef DIV_EARLY_OUT_EN
    logic                  w_early;
`endif

    // Magnitudes of the operands; negation only for signed ops with MSB set
    assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign w_abs1    = w_op1_neg ? -opdata1_i : opdata1_i;
    assign w_abs2    = w_op2_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign w_early   = (w_abs1 < w_abs2);
`endif

    // One restoring step: bring in the next dividend bit, trial-subtract divisor.
    // The partial value is below 2*divisor, so the low DATA_W bits of the
    // subtraction are exact whenever it does not borrow.
    assign w_partial = {r_rem, r_quot[DATA_W-1]};
    assign w_borrow  = (w_partial < {1'b0, r_divisor});
    assign w_rem_sub = w_partial[DATA_W-1:0] - r_divisor;

    // Sign fixup: quotient sign is the XOR of operand signs, remainder follows dividend
    assign w_quot_fix = (r_signed && (r_neg1 ^ r_neg2)) ? -r_quot : r_quot;
    assign w_rem_fix  = (r_signed && r_neg1) ? -r_rem : r_rem;

    // Next-state and output-register logic
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_signed_n  = r_signed;
        w_neg1_n    = r_neg1;
        w_neg2_n    = r_neg2;
        w_divisor_n = r_divisor;
        w_rem_n     = r_rem;
        w_quot_n    = r_quot;
        w_result_n  = r_result;
        w_ready_n   = r_ready;

        case (r_state)
            DivFree: begin
                w_result_n = '0;
                w_ready_n  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    w_signed_n  = signed_div_i;
                    w_neg1_n    = w_op1_neg;
                    w_neg2_n    = w_op2_neg;
                    w_divisor_n = w_abs2;
                    w_rem_n     = '0;
                    w_quot_n    = w_abs1;
                    w_cnt_n     = '0;
                    if (opdata2_i == '0) begin
                        w_state_n = DivByZero;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (w_early) begin
                        // Quotient is zero and the remainder is the dividend itself
                        w_state_n  = DivEnd;
                        w_result_n = {opdata1_i, {DATA_W{1'b0}}};
                        w_ready_n  = DivResultReady;
                    end
`endif
                    else begin
                        w_state_n = DivOn;
                    end
                end
            end

            DivByZero: begin
                w_state_n  = DivEnd;
                w_result_n = '0;
                w_ready_n  = DivResultReady;
            end

            DivOn: begin
                if (annul_i || start_i == DivStop) begin
                    w_state_n  = DivFree;
                    w_result_n = '0;
                    w_ready_n  = DivResultNotReady;
                    w_cnt_n    = '0;
                end else if (r_cnt != CntLast) begin
                    w_rem_n  = w_borrow ? w_partial[DATA_W-1:0] : w_rem_sub;
                    w_quot_n = {r_quot[DATA_W-2:0], ~w_borrow};
                    w_cnt_n  = r_cnt + CntOne;
                end else begin
                    w_state_n  = DivEnd;
                    w_result_n = {w_rem_fix, w_quot_fix};
                    w_ready_n  = DivResultReady;
                    w_cnt_n    = '0;
                end
            end

            DivEnd: begin
                // annul_i is deliberately ignored once the result is final
                if (start_i == DivStop) begin
                    w_state_n  = DivFree;
                    w_result_n = '0;
                    w_ready_n  = DivResultNotReady;
                end
            end

            default: begin
                w_state_n  = DivFree;
                w_result_n = '0;
                w_ready_n  = DivResultNotReady;
            end
        endcase
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DivFree;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_neg1    <= 1'b0;
            r_neg2    <= 1'b0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_signed  <= w_signed_n;
            r_neg1    <= w_neg1_n;
            r_neg2    <= w_neg2_n;
            r_divisor <= w_divisor_n;
            r_rem     <= w_rem_n;
            r_quot    <= w_quot_n;
            r_result  <= w_result_n;
            r_ready   <= w_ready_n;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes the expected
// {remainder, quotient} when it issues a request; a monitor pops and
// compares on every rising edge of ready_o.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];
    logic        prev_ready = 1'b0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EarlyLat = 0;
`else
    localparam int EarlyLat = 33;
`endif

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare each new result against the scoreboard
    always @(negedge clk) begin
        if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got %h expected no result", result_o);
            end else begin
                check(name_q.pop_front(), result_o, exp_q.pop_front());
            end
        end
        prev_ready = ready_o;
    end

    // Issue one operation, hold start until ready, check latency and release
    task automatic run_div(input string nm, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        logic seen;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        // Inputs after acceptance must not matter
        signed_div_i = ~sgn;
        opdata1_i    = ~a;
        opdata2_i    = 32'h1;
        n = 1;
        @(negedge clk);
        seen = ready_o;
        while (seen !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = ready_o;
        end
        check({nm, "_latency"}, 64'(n), 64'(lat + 1));
        repeat (2) @(negedge clk);
        check({nm, "_hold"}, {63'd0, ready_o}, 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        check({nm, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
        check({nm, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #3;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div("u_100_7",    1'b0, 32'd100,      32'd7,        {32'd2, 32'd14}, 33);
        run_div("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_div("s_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
        run_div("s_m100_7",   1'b1, 32'hFFFFFF9C, 32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
        run_div("u_5_0",      1'b0, 32'd5,        32'd0,        64'd0, 1);
        run_div("s_5_0",      1'b1, 32'd5,        32'd0,        64'd0, 1);
        run_div("s_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
        run_div("u_max_2",    1'b0, 32'hFFFFFFFF, 32'd2,        {32'd1, 32'h7FFFFFFF}, 33);
        run_div("u_small",    1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, EarlyLat);
        run_div("s_m3_10",    1'b1, 32'hFFFFFFFD, 32'd10,       {32'hFFFFFFFD, 32'd0}, EarlyLat);

        // Annul at E0+10: no result may appear even with start held
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        repeat (40) @(negedge clk);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        run_div("u_9_3_after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Asynchronous reset mid-operation
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_on_ready", {63'd0, ready_o}, 64'd0);
        check("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div("u_12_5_after_rst", 1'b0, 32'd12, 32'd5, {32'd2, 32'd2}, 33);

        // Asynchronous reset while a result is being held
        @(negedge clk);
        opdata1_i = 32'd20;
        opdata2_i = 32'd6;
        start_i   = 1'b1;
        exp_q.push_back({32'd2, 32'd3});
        name_q.push_back("u_20_6");
        for (int i = 0; i < 100 && ready_o !== 1'b1; i++) @(negedge clk);
        check("end_ready_before_rst", {63'd0, ready_o}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_end_ready", {63'd0, ready_o}, 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
